alu_operand_stage: RTL and testbench

ID/EX pipeline stage directly upstream of the ALU. Registers decoded operands, immediate and ALU control from decode, and drives alu_ra, alu_rb and cu_aluc into the ALU. Resolves read-after-write hazards by forwarding from the MEM and WB stages. Supports stall and flush from the hazard/branch logic.

---
 rtl/alu_operand_stage.sv | 132 +++++++++++++
 tb/tb_alu_operand_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage in front of the ALU. It registers decoded operands,
// the immediate and the ALU control, and supports stall and flush.
// Optional feature macro: ALU_FWD_EN. When it is defined, MEM/WB results are
// forwarded onto alu_ra/alu_rb, and a stalled stage refreshes its stored
// operands from active forwarding hits. When it is undefined, the stored
// registers drive the ALU directly and the mem_*/wb_* inputs are ignored.
module alu_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DATA_W-1:0] id_ra_data,
  input  logic [DATA_W-1:0] id_rb_data,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [3:0]        id_aluc,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_wr_en,
  input  logic              ex_stall,
  input  logic              ex_flush,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0] wb_wr_data,
  output logic [DATA_W-1:0] alu_ra,
  output logic [DATA_W-1:0] alu_rb,
  output logic [3:0]        cu_aluc,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_wr_addr,
  output logic              ex_wr_en
);

  logic              valid_q;
  logic [DATA_W-1:0] ra_q;
  logic [DATA_W-1:0] rb_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic              b_is_imm_q;
  logic [3:0]        aluc_q;
  logic [REG_AW-1:0] wr_addr_q;
  logic              wr_en_q;

  // Operand values after forwarding, and whether a forward is active
  logic [DATA_W-1:0] fwd_ra;
  logic [DATA_W-1:0] fwd_rb;
  logic              hit_a;
  logic              hit_b;

`ifdef ALU_FWD_EN
  logic mem_hit_a;
  logic wb_hit_a;
  logic mem_hit_b;
  logic wb_hit_b;

  // Hit detection; register 0 is never forwarded, and an immediate B never is
  always_comb begin
    mem_hit_a = mem_wr_en && (mem_wr_addr == rs_q) && (rs_q != '0);
    wb_hit_a  = wb_wr_en && (wb_wr_addr == rs_q) && (rs_q != '0);
    mem_hit_b = mem_wr_en && (mem_wr_addr == rt_q) && (rt_q != '0) && !b_is_imm_q;
    wb_hit_b  = wb_wr_en && (wb_wr_addr == rt_q) && (rt_q != '0) && !b_is_imm_q;
  end

  // Operand muxes: MEM is younger than WB, so MEM wins
  always_comb begin
    fwd_ra = ra_q;
    fwd_rb = rb_q;
    if (mem_hit_a)     fwd_ra = mem_wr_data;
    else if (wb_hit_a) fwd_ra = wb_wr_data;
    if (mem_hit_b)     fwd_rb = mem_wr_data;
    else if (wb_hit_b) fwd_rb = wb_wr_data;
    hit_a = mem_hit_a | wb_hit_a;
    hit_b = mem_hit_b | wb_hit_b;
  end
`else
  logic unused_fwd;

  // Without forwarding the stored registers feed the ALU directly
  always_comb begin
    fwd_ra     = ra_q;
    fwd_rb     = rb_q;
    hit_a      = 1'b0;
    hit_b      = 1'b0;
    unused_fwd = ^{mem_wr_en, mem_wr_addr, mem_wr_data, wb_wr_en, wb_wr_addr, wb_wr_data,
                   rs_q, rt_q, b_is_imm_q};
  end
`endif

  // Stage register: reset > flush > stall (with operand refresh) > capture
  always_ff @(posedge clk) begin
    if (!rst_n || ex_flush) begin
      valid_q    <= 1'b0;
      ra_q       <= '0;
      rb_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      b_is_imm_q <= 1'b0;
      aluc_q     <= '0;
      wr_addr_q  <= '0;
      wr_en_q    <= 1'b0;
    end else if (ex_stall) begin
      // Latch forwarded values so they survive the producer retiring
      if (hit_a) ra_q <= fwd_ra;
      if (hit_b) rb_q <= fwd_rb;
    end else begin
      valid_q    <= id_valid;
      ra_q       <= id_ra_data;
      rb_q       <= id_use_imm ? id_imm : id_rb_data;
      rs_q       <= id_rs_addr;
      rt_q       <= id_rt_addr;
      b_is_imm_q <= id_use_imm;
      aluc_q     <= id_aluc;
      wr_addr_q  <= id_wr_addr;
      wr_en_q    <= id_wr_en & id_valid;
    end
  end

  assign id_ready   = !ex_stall;
  assign alu_ra     = fwd_ra;
  assign alu_rb     = fwd_rb;
  assign cu_aluc    = aluc_q;
  assign ex_valid   = valid_q;
  assign ex_wr_addr = wr_addr_q;
  assign ex_wr_en   = wr_en_q & valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage. Expectations for forwarded operands
// follow the ALU_FWD_EN build option.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ra_data;
  logic [31:0] id_rb_data;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [31:0] id_imm;
  logic        id_use_imm;
  logic [3:0]  id_aluc;
  logic [4:0]  id_wr_addr;
  logic        id_wr_en;
  logic        ex_stall;
  logic        ex_flush;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        wb_wr_en;
  logic [4:0]  wb_wr_addr;
  logic [31:0] wb_wr_data;
  logic [31:0] alu_ra;
  logic [31:0] alu_rb;
  logic [3:0]  cu_aluc;
  logic        ex_valid;
  logic [4:0]  ex_wr_addr;
  logic        ex_wr_en;

  int total = 0;
  int bad   = 0;

`ifdef ALU_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  alu_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_ra_data  (id_ra_data),
    .id_rb_data  (id_rb_data),
    .id_rs_addr  (id_rs_addr),
    .id_rt_addr  (id_rt_addr),
    .id_imm      (id_imm),
    .id_use_imm  (id_use_imm),
    .id_aluc     (id_aluc),
    .id_wr_addr  (id_wr_addr),
    .id_wr_en    (id_wr_en),
    .ex_stall    (ex_stall),
    .ex_flush    (ex_flush),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_addr  (wb_wr_addr),
    .wb_wr_data  (wb_wr_data),
    .alu_ra      (alu_ra),
    .alu_rb      (alu_rb),
    .cu_aluc     (cu_aluc),
    .ex_valid    (ex_valid),
    .ex_wr_addr  (ex_wr_addr),
    .ex_wr_en    (ex_wr_en)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] ra, input logic [31:0] rb,
                        input logic [4:0] rs, input logic [4:0] rt, input logic ui,
                        input logic [31:0] imm, input logic [3:0] aluc,
                        input logic [4:0] wa, input logic we);
    id_valid   = v;
    id_ra_data = ra;
    id_rb_data = rb;
    id_rs_addr = rs;
    id_rt_addr = rt;
    id_use_imm = ui;
    id_imm     = imm;
    id_aluc    = aluc;
    id_wr_addr = wa;
    id_wr_en   = we;
  endtask

  initial begin
    rst_n = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;
    mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
    wb_wr_en = 1'b0; wb_wr_addr = '0; wb_wr_data = '0;
    set_id(1'b1, 32'h12, 32'h34, 5'd1, 5'd2, 1'b0, 32'h0, 4'h9, 5'd7, 1'b1);

    // Reset held for two edges with a valid instruction presented
    step(); step();
    chk("rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_wr_en", {31'b0, ex_wr_en}, 32'h0);
    chk("rst_ra", alu_ra, 32'h0);
    chk("rst_rb", alu_rb, 32'h0);
    chk("rst_aluc", {28'b0, cu_aluc}, 32'h0);
    chk("rst_wr_addr", {27'b0, ex_wr_addr}, 32'h0);
    chk("rst_ready", {31'b0, id_ready}, 32'h1);

    // Basic capture, one-cycle latency
    rst_n = 1'b1;
    set_id(1'b1, 32'h5, 32'h7, 5'd1, 5'd2, 1'b0, 32'h0, 4'b0001, 5'd9, 1'b1);
    step();
    chk("cap_ra", alu_ra, 32'h5);
    chk("cap_rb", alu_rb, 32'h7);
    chk("cap_aluc", {28'b0, cu_aluc}, 32'h1);
    chk("cap_valid", {31'b0, ex_valid}, 32'h1);
    chk("cap_wr_en", {31'b0, ex_wr_en}, 32'h1);
    chk("cap_wr_addr", {27'b0, ex_wr_addr}, 32'd9);

    // Forward priority on rs=3: MEM over WB, then WB alone
    set_id(1'b1, 32'h30, 32'h40, 5'd3, 5'd4, 1'b0, 32'h0, 4'h2, 5'd10, 1'b1);
    step();
    mem_wr_en = 1'b1; mem_wr_addr = 5'd3; mem_wr_data = 32'hAA;
    wb_wr_en  = 1'b1; wb_wr_addr  = 5'd3; wb_wr_data  = 32'hBB;
    #1;
    chk("fwd_mem_pri", alu_ra, Fwd ? 32'hAA : 32'h30);
    chk("fwd_rb_nohit", alu_rb, 32'h40);
    mem_wr_en = 1'b0;
    #1;
    chk("fwd_wb", alu_ra, Fwd ? 32'hBB : 32'h30);
    wb_wr_en = 1'b0;
    #1;
    chk("fwd_none", alu_ra, 32'h30);

    // Bubble: id_valid=0 with id_wr_en=1 must not write
    set_id(1'b0, 32'h1, 32'h2, 5'd1, 5'd2, 1'b0, 32'h0, 4'h3, 5'd11, 1'b1);
    step();
    chk("bub_valid", {31'b0, ex_valid}, 32'h0);
    chk("bub_wr_en", {31'b0, ex_wr_en}, 32'h0);

    // Register 0 never forwarded; immediate B never forwarded
    set_id(1'b1, 32'h11, 32'h66, 5'd0, 5'd6, 1'b1, 32'h10, 4'h4, 5'd12, 1'b1);
    step();
    mem_wr_en = 1'b1; mem_wr_addr = 5'd0; mem_wr_data = 32'hFF;
    #1;
    chk("zero_reg_ra", alu_ra, 32'h11);
    chk("imm_rb", alu_rb, 32'h10);
    mem_wr_addr = 5'd6;
    #1;
    chk("imm_no_fwd", alu_rb, 32'h10);
    mem_wr_en = 1'b0;

    // Stall with WB refresh of rt=2 in the first stall cycle only
    set_id(1'b1, 32'h21, 32'h22, 5'd1, 5'd2, 1'b0, 32'h0, 4'h5, 5'd13, 1'b1);
    step();
    chk("pre_stall_rb", alu_rb, 32'h22);
    ex_stall = 1'b1;
    set_id(1'b1, 32'h91, 32'h99, 5'd8, 5'd9, 1'b0, 32'h0, 4'h7, 5'd14, 1'b0);
    wb_wr_en = 1'b1; wb_wr_addr = 5'd2; wb_wr_data = 32'h55;
    #1;
    chk("stall_ready", {31'b0, id_ready}, 32'h0);
    chk("stall_c1_rb", alu_rb, Fwd ? 32'h55 : 32'h22);
    step();
    wb_wr_en = 1'b0;
    #1;
    chk("stall_c2_rb", alu_rb, Fwd ? 32'h55 : 32'h22);
    chk("stall_hold_ra", alu_ra, 32'h21);
    chk("stall_hold_aluc", {28'b0, cu_aluc}, 32'h5);
    step();
    chk("stall_c3_rb", alu_rb, Fwd ? 32'h55 : 32'h22);
    chk("stall_hold_addr", {27'b0, ex_wr_addr}, 32'd13);
    step();
    ex_stall = 1'b0;
    #1;
    chk("release_rb", alu_rb, Fwd ? 32'h55 : 32'h22);
    chk("release_wr_en", {31'b0, ex_wr_en}, 32'h1);

    // Flush wins over stall, then normal capture resumes
    ex_stall = 1'b1; ex_flush = 1'b1;
    step();
    chk("flush_valid", {31'b0, ex_valid}, 32'h0);
    chk("flush_wr_en", {31'b0, ex_wr_en}, 32'h0);
    chk("flush_ra", alu_ra, 32'h0);
    chk("flush_aluc", {28'b0, cu_aluc}, 32'h0);
    ex_stall = 1'b0; ex_flush = 1'b0;
    set_id(1'b1, 32'hDEAD, 32'hBEEF, 5'd5, 5'd6, 1'b0, 32'h0, 4'hC, 5'd15, 1'b1);
    step();
    chk("post_flush_ra", alu_ra, 32'hDEAD);
    chk("post_flush_rb", alu_rb, 32'hBEEF);
    chk("post_flush_aluc", {28'b0, cu_aluc}, 32'hC);
    chk("post_flush_valid", {31'b0, ex_valid}, 32'h1);

    // Reset wins over stall
    rst_n = 1'b0; ex_stall = 1'b1;
    step();
    chk("rst_over_stall", {31'b0, ex_valid}, 32'h0);
    chk("rst_over_stall_ra", alu_ra, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
